// File: rtl/guess_input.sv
// PS/2 keyboard front end for the hangman game: deserializes scan-code-set-2 frames and
// turns letter/Enter make codes into a one-cycle load pulse with a letter index.
module guess_input #(
  parameter int FILTER_LEN     = 4,
  parameter int TIMEOUT_CYCLES = 50000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic       load,
  output logic [4:0] load_x,
  output logic       frame_error
);

  localparam int FW = $clog2(FILTER_LEN + 1);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [FW-1:0] FILT_MAX = FW'(FILTER_LEN - 1);
  localparam logic [TW-1:0] TIME_MAX = TW'(TIMEOUT_CYCLES - 1);

  typedef enum logic {RX_IDLE, RX_RECV} rx_state_t;
  typedef enum logic [1:0] {DEC_MAKE, DEC_BREAK, DEC_EXT, DEC_EXT_BREAK} dec_state_t;

  logic          clk_s1, clk_s2, data_s1, data_s2;
  logic          filt_clk, fall;
  logic [FW-1:0] filt_cnt;

  rx_state_t     rx_state;
  logic [3:0]    bit_cnt;
  logic [7:0]    shift;
  logic          parity, start_bad;
  logic [TW-1:0] timer;
  logic          byte_valid;
  logic [7:0]    rx_byte;

  dec_state_t    dec_state;
  logic [7:0]    held;
  logic [5:0]    mapped;

  // Two-flop synchronizers, then a level filter: the filtered clock only follows a new
  // level after FILTER_LEN consecutive agreeing samples, so short glitches are swallowed.
  always_ff @(posedge clk) begin
    if (reset) begin
      clk_s1   <= 1'b1;
      clk_s2   <= 1'b1;
      data_s1  <= 1'b1;
      data_s2  <= 1'b1;
      filt_clk <= 1'b1;
      filt_cnt <= '0;
      fall     <= 1'b0;
    end else begin
      clk_s1  <= ps2_clk;
      clk_s2  <= clk_s1;
      data_s1 <= ps2_data;
      data_s2 <= data_s1;
      fall    <= 1'b0;
      if (clk_s2 != filt_clk) begin
        if (filt_cnt == FILT_MAX) begin
          filt_clk <= clk_s2;
          filt_cnt <= '0;
          fall     <= filt_clk & ~clk_s2;
        end else begin
          filt_cnt <= filt_cnt + FW'(1);
        end
      end else begin
        filt_cnt <= '0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rx_state    <= RX_IDLE;
      bit_cnt     <= '0;
      shift       <= '0;
      parity      <= 1'b0;
      start_bad   <= 1'b0;
      timer       <= '0;
      byte_valid  <= 1'b0;
      rx_byte     <= '0;
      frame_error <= 1'b0;
    end else begin
      byte_valid  <= 1'b0;
      frame_error <= 1'b0;
      case (rx_state)
        RX_IDLE: begin
          timer <= '0;
          if (fall) begin
            start_bad <= data_s2;
            bit_cnt   <= 4'd1;
            rx_state  <= RX_RECV;
          end
        end
        RX_RECV: begin
          if (fall) begin
            timer <= '0;
            if (bit_cnt <= 4'd8) begin
              shift   <= {data_s2, shift[7:1]};
              bit_cnt <= bit_cnt + 4'd1;
            end else if (bit_cnt == 4'd9) begin
              parity  <= data_s2;
              bit_cnt <= bit_cnt + 4'd1;
            end else begin
              // Stop bit: accept only with a low start bit, high stop bit and odd parity.
              if (!start_bad && data_s2 && (^{parity, shift})) begin
                byte_valid <= 1'b1;
                rx_byte    <= shift;
              end else begin
                frame_error <= 1'b1;
              end
              rx_state <= RX_IDLE;
            end
          end else if (timer == TIME_MAX) begin
            frame_error <= 1'b1;
            rx_state    <= RX_IDLE;
          end else begin
            timer <= timer + TW'(1);
          end
        end
        default: rx_state <= RX_IDLE;
      endcase
    end
  end

  function automatic logic [5:0] map_code(input logic [7:0] code);
    case (code)
      8'h1C: return {1'b1, 5'd0};
      8'h32: return {1'b1, 5'd1};
      8'h21: return {1'b1, 5'd2};
      8'h23: return {1'b1, 5'd3};
      8'h24: return {1'b1, 5'd4};
      8'h2B: return {1'b1, 5'd5};
      8'h34: return {1'b1, 5'd6};
      8'h33: return {1'b1, 5'd7};
      8'h43: return {1'b1, 5'd8};
      8'h3B: return {1'b1, 5'd9};
      8'h42: return {1'b1, 5'd10};
      8'h4B: return {1'b1, 5'd11};
      8'h3A: return {1'b1, 5'd12};
      8'h31: return {1'b1, 5'd13};
      8'h44: return {1'b1, 5'd14};
      8'h4D: return {1'b1, 5'd15};
      8'h15: return {1'b1, 5'd16};
      8'h2D: return {1'b1, 5'd17};
      8'h1B: return {1'b1, 5'd18};
      8'h2C: return {1'b1, 5'd19};
      8'h3C: return {1'b1, 5'd20};
      8'h2A: return {1'b1, 5'd21};
      8'h1D: return {1'b1, 5'd22};
      8'h22: return {1'b1, 5'd23};
      8'h35: return {1'b1, 5'd24};
      8'h1A: return {1'b1, 5'd25};
      8'h5A: return {1'b1, 5'd26};
      default: return 6'd0;
    endcase
  endfunction

  assign mapped = map_code(rx_byte);

  // held remembers the last make code so typematic repeats of the same key stay silent
  // until its break code arrives; 8'h00 never maps, so it doubles as "nothing held".
  always_ff @(posedge clk) begin
    if (reset) begin
      dec_state <= DEC_MAKE;
      held      <= '0;
      load      <= 1'b0;
      load_x    <= '0;
    end else begin
      load <= 1'b0;
      if (byte_valid) begin
        case (dec_state)
          DEC_MAKE: begin
            if (rx_byte == 8'hF0) begin
              dec_state <= DEC_BREAK;
            end else if (rx_byte == 8'hE0) begin
              dec_state <= DEC_EXT;
            end else if (mapped[5]) begin
              if (rx_byte != held) begin
                load   <= 1'b1;
                load_x <= mapped[4:0];
              end
              held <= rx_byte;
            end
          end
          DEC_BREAK: begin
            if (rx_byte == held) held <= '0;
            dec_state <= DEC_MAKE;
          end
          DEC_EXT: begin
            dec_state <= (rx_byte == 8'hF0) ? DEC_EXT_BREAK : DEC_MAKE;
          end
          default: dec_state <= DEC_MAKE;
        endcase
      end
    end
  end

endmodule
